// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches enabled per-source requests, signals the lowest-index
// pending source to the core and runs a claim/complete handshake around it.
module irq_arbiter #(
  parameter int              NSRC     = 13,
  parameter int              IDW      = 4,
  parameter logic [NSRC-1:0] EN_RESET = 13'b0000001101101
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] status,
  input  logic            en_we,
  input  logic [NSRC-1:0] en_wdata,
  output logic [NSRC-1:0] en_mask,
  output logic [NSRC-1:0] pending,
  input  logic            claim,
  output logic            claim_valid,
  output logic [IDW-1:0]  claim_id,
  input  logic            complete,
  input  logic [IDW-1:0]  complete_id,
  output logic            interrupt
);

  localparam logic [IDW-1:0] NONE_ID = '1;

  typedef enum logic [1:0] {
    IDLE,
    SIGNAL,
    SERVICE
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  cur_id_q, cur_id_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] en_mask_q, en_mask_d;
  logic            interrupt_q, interrupt_d;
  logic            claim_valid_q, claim_valid_d;
  logic [IDW-1:0]  claim_id_q, claim_id_d;

  logic [IDW-1:0]  winner_id;
  logic            any_pending;
  logic            claim_accept;
  logic [NSRC-1:0] set_vec;
  logic [NSRC-1:0] clr_vec;

  assign claim_accept = (state_q == SIGNAL) && claim;

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    winner_id   = NONE_ID;
    any_pending = |pending_q;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pending_q[i]) winner_id = IDW'(i);
    end
  end

  // The source in service is masked from re-pending until it is completed.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    set_vec   = '0;
    clr_vec   = '0;
    en_mask_d = en_we ? en_wdata : en_mask_q;
    for (int i = 0; i < NSRC; i++) begin
      clr_vec[i] = claim_accept && (cur_id_q == IDW'(i));
      set_vec[i] = status[i] && en_mask_q[i] && !clr_vec[i]
                   && !((state_q == SERVICE) && (cur_id_q == IDW'(i)));
    end
    pending_d = ((pending_q & ~clr_vec) | set_vec) & en_mask_d;
  end

  always_comb begin
    state_d       = state_q;
    cur_id_d      = cur_id_q;
    interrupt_d   = interrupt_q;
    claim_valid_d = claim;
    claim_id_d    = claim ? NONE_ID : claim_id_q;
    unique case (state_q)
      IDLE: begin
        interrupt_d = 1'b0;
        if (any_pending) begin
          state_d     = SIGNAL;
          cur_id_d    = winner_id;
          interrupt_d = 1'b1;
        end
      end
      SIGNAL: begin
        if (claim) begin
          claim_id_d  = cur_id_q;
          state_d     = SERVICE;
          interrupt_d = 1'b0;
        end else if (!any_pending) begin
          state_d     = IDLE;
          cur_id_d    = NONE_ID;
          interrupt_d = 1'b0;
        end else begin
          cur_id_d    = winner_id;
          interrupt_d = 1'b1;
        end
      end
      SERVICE: begin
        interrupt_d = 1'b0;
        if (complete && (complete_id == cur_id_q)) begin
          state_d  = IDLE;
          cur_id_d = NONE_ID;
        end
      end
      default: begin
        state_d     = IDLE;
        cur_id_d    = NONE_ID;
        interrupt_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_id_q      <= NONE_ID;
      pending_q     <= '0;
      en_mask_q     <= EN_RESET;
      interrupt_q   <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= NONE_ID;
    end else begin
      state_q       <= state_d;
      cur_id_q      <= cur_id_d;
      pending_q     <= pending_d;
      en_mask_q     <= en_mask_d;
      interrupt_q   <= interrupt_d;
      claim_valid_q <= claim_valid_d;
      claim_id_q    <= claim_id_d;
    end
  end

  assign en_mask     = en_mask_q;
  assign pending     = pending_q;
  assign interrupt   = interrupt_q;
  assign claim_valid = claim_valid_q;
  assign claim_id    = claim_id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: inputs are driven and outputs sampled 1ns after
// each rising edge, against hand-computed expectations.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] status;
  logic        en_we;
  logic [12:0] en_wdata;
  logic [12:0] en_mask;
  logic [12:0] pending;
  logic        claim;
  logic        claim_valid;
  logic [3:0]  claim_id;
  logic        complete;
  logic [3:0]  complete_id;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  irq_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .status      (status),
    .en_we       (en_we),
    .en_wdata    (en_wdata),
    .en_mask     (en_mask),
    .pending     (pending),
    .claim       (claim),
    .claim_valid (claim_valid),
    .claim_id    (claim_id),
    .complete    (complete),
    .complete_id (complete_id),
    .interrupt   (interrupt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; status = '0; en_we = 1'b0; en_wdata = '0;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    step(); step();
    check("rst_pending", pending, 13'h000);
    check("rst_en_mask", en_mask, 13'h06D);
    check("rst_interrupt", interrupt, 1'b0);
    check("rst_claim_valid", claim_valid, 1'b0);
    check("rst_claim_id", claim_id, 4'hF);

    // Single source 2: pending at edge 1, interrupt at edge 2, then claim.
    rst = 1'b0; status = 13'h004;
    step();
    check("t1_pending", pending, 13'h004);
    check("t1_irq_low", interrupt, 1'b0);
    step();
    check("t1_irq_high", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t1_claim_valid", claim_valid, 1'b1);
    check("t1_claim_id", claim_id, 4'd2);
    check("t1_pending_clr", pending, 13'h000);
    check("t1_irq_drop", interrupt, 1'b0);
    claim = 1'b0;
    step();
    check("t1_cv_pulse", claim_valid, 1'b0);
    check("t1_id_hold", claim_id, 4'd2);
    check("t1_svc_no_repend", pending, 13'h000);

    // In service for 2: mismatched complete ignored, claim returns NONE.
    complete = 1'b1; complete_id = 4'd3;
    step();
    check("t5_bad_cmp_irq", interrupt, 1'b0);
    complete = 1'b0; claim = 1'b1;
    step();
    check("t5_svc_claim_cv", claim_valid, 1'b1);
    check("t5_svc_claim_none", claim_id, 4'hF);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd2;
    step();
    check("t5_cmp_pending", pending, 13'h000);
    complete = 1'b0;
    step();
    check("t5_repend", pending, 13'h004);
    step();
    check("t5_irq_reassert", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t5_reclaim_id", claim_id, 4'd2);
    claim = 1'b0; status = '0; complete = 1'b1; complete_id = 4'd2;
    step();
    complete = 1'b0;
    step();
    check("t5_idle_irq", interrupt, 1'b0);
    check("t5_idle_pending", pending, 13'h000);

    // Sources 3,5,6 served in priority order, each returning through IDLE.
    status = 13'h068;
    step();
    check("t2_pending", pending, 13'h068);
    step();
    check("t2_irq", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t2_claim3", claim_id, 4'd3);
    check("t2_pend_after3", pending, 13'h060);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd3; status = 13'h060;
    step();
    check("t2_irq_idle3", interrupt, 1'b0);
    complete = 1'b0;
    step();
    check("t2_irq5", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t2_claim5", claim_id, 4'd5);
    check("t2_pend_after5", pending, 13'h040);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd5; status = 13'h040;
    step();
    complete = 1'b0;
    step();
    check("t2_irq6", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t2_claim6", claim_id, 4'd6);
    check("t2_pend_after6", pending, 13'h000);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd6; status = '0;
    step();
    complete = 1'b0;
    step();
    check("t2_done_irq", interrupt, 1'b0);

    // Preemption: source 0 arrives while 5 is being signalled.
    status = 13'h020;
    step(); step();
    check("t3_irq5", interrupt, 1'b1);
    status = 13'h021;
    step();
    check("t3_pend_both", pending, 13'h021);
    step();
    claim = 1'b1;
    step();
    check("t3_claim0", claim_id, 4'd0);
    check("t3_pend_left", pending, 13'h020);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd0; status = 13'h020;
    step();
    complete = 1'b0;
    step();
    check("t3_irq_again", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t3_claim5", claim_id, 4'd5);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd5; status = '0;
    step();
    complete = 1'b0;
    step();
    check("t3_done_irq", interrupt, 1'b0);

    // Masked source 1 stays quiet until enabled.
    status = 13'h002;
    step(); step();
    check("t4_masked_pend", pending, 13'h000);
    check("t4_masked_irq", interrupt, 1'b0);
    en_we = 1'b1; en_wdata = 13'h002;
    step();
    check("t4_mask_loaded", en_mask, 13'h002);
    en_we = 1'b0;
    step();
    check("t4_pend1", pending, 13'h002);
    step();
    check("t4_irq1", interrupt, 1'b1);
    claim = 1'b1;
    step();
    check("t4_claim1", claim_id, 4'd1);
    claim = 1'b0; complete = 1'b1; complete_id = 4'd1; status = '0;
    step();
    complete = 1'b0;
    step();

    // Synchronous reset while signalling.
    status = 13'h002;
    step(); step();
    check("t6_irq_pre_rst", interrupt, 1'b1);
    rst = 1'b1; status = '0;
    step();
    check("t6_rst_irq", interrupt, 1'b0);
    check("t6_rst_pend", pending, 13'h000);
    check("t6_rst_mask", en_mask, 13'h06D);
    check("t6_rst_claim_id", claim_id, 4'hF);
    rst = 1'b0;
    step();

    // Mask write drops the only pending source while signalling.
    status = 13'h008;
    step(); step();
    check("t6_irq3", interrupt, 1'b1);
    en_we = 1'b1; en_wdata = 13'h065;
    step();
    check("t6_mask_clr_pend", pending, 13'h000);
    check("t6_mask_val", en_mask, 13'h065);
    en_we = 1'b0;
    step();
    check("t6_back_idle_irq", interrupt, 1'b0);
    claim = 1'b1;
    step();
    check("t6_idle_claim_cv", claim_valid, 1'b1);
    check("t6_idle_claim_none", claim_id, 4'hF);
    claim = 1'b0;
    step();
    check("t6_idle_cv_drop", claim_valid, 1'b0);
    check("t6_idle_still", interrupt, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
